// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, with a sign fix-up cycle.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [7:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [7:0] ExeMthiOp  = 8'b0001_0001;
    localparam logic [7:0] ExeMtloOp  = 8'b0001_0011;
    localparam logic [7:0] ExeMultOp  = 8'b0001_1000;
    localparam logic [7:0] ExeMultuOp = 8'b0001_1001;
    localparam logic [7:0] ExeDivOp   = 8'b0001_1010;
    localparam logic [7:0] ExeDivuOp  = 8'b0001_1011;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StFix  = 2'd3;

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic               is_div_q, is_div_d;
    logic               sign_q, sign_d, sign_r_q, sign_r_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    logic             op_mul, op_div, op_signed, a_neg, b_neg;
    logic [WIDTH:0]   mul_sum, rem_shift;
    logic [WIDTH-1:0] rem_sub, quo_fix, rem_fix, a_orig;
    logic [2*WIDTH-1:0] prod_fix;
    logic             rem_ge;

    assign op_mul    = (alucontrol == ExeMultOp) || (alucontrol == ExeMultuOp);
    assign op_div    = (alucontrol == ExeDivOp) || (alucontrol == ExeDivuOp);
    assign op_signed = (alucontrol == ExeMultOp) || (alucontrol == ExeDivOp);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? mag_a_q : {WIDTH{1'b0}})};

    // Divide: acc low half shifts dividend bits out and quotient bits in.
    assign rem_shift = {rem_q, acc_q[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, mag_b_q};
    assign rem_sub   = rem_shift[WIDTH-1:0] - mag_b_q;

    assign prod_fix = sign_q ? -acc_q : acc_q;
    assign quo_fix  = sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sign_r_q ? -rem_q : rem_q;
    // Remainder sign equals the dividend sign, so this rebuilds the original dividend.
    assign a_orig   = sign_r_q ? -mag_a_q : mag_a_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        sign_r_d = sign_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    if (alucontrol == ExeMthiOp) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (alucontrol == ExeMtloOp) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end else if (op_mul || op_div) begin
                        state_d  = op_mul ? StMul : StDiv;
                        mag_a_d  = a_neg ? -a : a;
                        mag_b_d  = b_neg ? -b : b;
                        sign_d   = a_neg ^ b_neg;
                        sign_r_d = a_neg;
                        is_div_d = op_div;
                        cnt_d    = '0;
                        rem_d    = '0;
                        acc_d    = {{WIDTH{1'b0}}, (op_mul ? mag_b_d : mag_a_d)};
                    end
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastIter) state_d = StFix;
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], rem_ge};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastIter) state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (mag_b_q == '0) begin
                        hi_d  = a_orig;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d  = rem_fix;
                        lo_d  = quo_fix;
                        dbz_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            sign_r_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            sign_r_q <= sign_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
